// File: rtl/uart_pkg.sv
// Shared UART receiver types and oversampling constants.
// UART_RX_PARITY_EN adds the even-parity state.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  localparam logic [3:0] MID_TICK  = 4'd8;
  localparam logic [3:0] SAMP_A    = 4'd7;
  localparam logic [3:0] SAMP_B    = 4'd8;
  localparam logic [3:0] SAMP_C    = 4'd9;
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte output bundle of the UART receiver.
// The receiver drives it through the master modport.
interface uart_rx_if;
  import uart_pkg::*;

  logic       rxReady;
  logic [7:0] rxData;
  logic       rxError;
  logic       rxBusy;

  modport master (
    output rxReady,
    output rxData,
    output rxError,
    output rxBusy
  );

  modport slave (
    input rxReady,
    input rxData,
    input rxError,
    input rxBusy
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one pulse every DIV clocks.
// A synchronous restart realigns the phase to a start edge.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TOP = CW'(DIV - 1);

  if (DIV < 1) begin : g_div_chk
    $error("uart_baud_tick: DIV must be at least 1");
  end

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || cnt_q == TOP) begin
      cnt_d = '0;
    end
  end

  assign tick = (cnt_q == TOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 16x oversampled 8N1 UART receiver with majority voting.
// Define UART_RX_PARITY_EN for an even-parity bit before stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rxd,
  uart_rx_if.master rx_if
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);

  logic       sync1_q, sync2_q, prev_q;
  rx_state_e  state_q, state_d;
  logic [3:0] tcnt_q, tcnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] data_q, data_d;
  logic       s7_q, s7_d;
  logic       s8_q, s8_d;
  logic       rdy_q, rdy_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic       par_q, par_d;
`endif

  logic rx_s;
  logic maj;
  logic tick;
  logic restart;

  assign rx_s = sync2_q;
  assign maj  = maj3(s7_q, s8_q, rx_s);

  uart_baud_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(restart),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    s7_d    = s7_q;
    s8_d    = s8_q;
    rdy_d   = 1'b0;
    err_d   = 1'b0;
    busy_d  = busy_q;
    restart = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif

    if (tick) begin
      unique case (1'b1)
        (tcnt_q == SAMP_A): s7_d = rx_s;
        (tcnt_q == SAMP_B): s8_d = rx_s;
        default: ;
      endcase
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s && prev_q) begin
          state_d = ST_START;
          tcnt_d  = '0;
          busy_d  = 1'b1;
          restart = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == MID_TICK && rx_s) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else if (tcnt_q == LAST_TICK) begin
            state_d = ST_DATA;
            bit_d   = '0;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == SAMP_C) begin
            shreg_d = {maj, shreg_q[7:1]};
          end
          if (tcnt_q == LAST_TICK) begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == SAMP_C) begin
            par_d = maj;
          end
          if (tcnt_q == LAST_TICK) begin
            state_d = ST_STOP;
          end
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == SAMP_C) begin
            if (maj) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
              if (^{shreg_q, par_q}) begin
                err_d = 1'b1;
              end else begin
                data_d = shreg_q;
                rdy_d  = 1'b1;
              end
`else
              data_d = shreg_q;
              rdy_d  = 1'b1;
`endif
            end else begin
              err_d   = 1'b1;
              state_d = ST_BREAK;
              tcnt_d  = '0;
            end
          end
        end
      end
      ST_BREAK: begin
        // Needs a full bit time of continuous idle before re-arming
        if (tick) begin
          if (!rx_s) begin
            tcnt_d = '0;
          end else if (tcnt_q == LAST_TICK) begin
            tcnt_d  = '0;
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= ST_IDLE;
      tcnt_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      s7_q    <= 1'b1;
      s8_q    <= 1'b1;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      s7_q    <= s7_d;
      s8_q    <= s8_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign rx_if.rxReady = rdy_q;
  assign rx_if.rxData  = data_q;
  assign rx_if.rxError = err_q;
  assign rx_if.rxBusy  = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIV=1 (16 clocks per bit).
// Define UART_RX_PARITY_EN to also run the parity frames.
module tb_uart_rx;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic rxd   = 1'b1;

  always #5 clk = ~clk;

  uart_rx_if rx_if ();

  uart_rx #(
    .CLK_FREQ(16000000),
    .BAUD    (1000000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rxd  (rxd),
    .rx_if(rx_if)
  );

  int n_chk = 0;
  int n_bad = 0;

  int rdy_cnt  = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  int dchg_cnt = 0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] got_q[$];

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rx_if.rxReady) begin
      rdy_cnt <= rdy_cnt + 1;
      got_q.push_back(rx_if.rxData);
    end
    if (rx_if.rxError) err_cnt <= err_cnt + 1;
    if (rx_if.rxReady && rx_if.rxError) both_cnt <= both_cnt + 1;
    if (rst_n && rx_if.rxData !== last_data && !rx_if.rxReady)
      dchg_cnt <= dchg_cnt + 1;
    last_data <= rx_if.rxData;
  end

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic v);
    rxd = v;
    tick_n(16);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stp);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^b);
`endif
    send_bit(stp);
    rxd = 1'b1;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_p(input logic [7:0] b, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(1'b1);
    rxd = 1'b1;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0;
    int e0;
    int qs;
    logic busy_seen;
    logic [7:0] v;

    #1 rst_n = 1'b0;
    tick_n(4);
    check("rst_rdy",  rx_if.rxReady, 0);
    check("rst_data", rx_if.rxData,  0);
    check("rst_err",  rx_if.rxError, 0);
    check("rst_busy", rx_if.rxBusy,  0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick_n(20);

    r0 = rdy_cnt; e0 = err_cnt;
    send_frame(8'h0A, 1'b1);
    tick_n(20);
    check("f0a_rdy",  rdy_cnt - r0, 1);
    check("f0a_data", rx_if.rxData, 8'h0A);
    check("f0a_err",  err_cnt - e0, 0);

    r0 = rdy_cnt; e0 = err_cnt;
    rxd = 1'b0;
    tick_n(4);
    busy_seen = rx_if.rxBusy;
    rxd = 1'b1;
    tick_n(10);
    check("gl_busy_seen", busy_seen, 1);
    check("gl_busy_drop", rx_if.rxBusy, 0);
    tick_n(20);
    check("gl_rdy", rdy_cnt - r0, 0);
    check("gl_err", err_cnt - e0, 0);

    r0 = rdy_cnt; e0 = err_cnt;
    send_frame(8'h55, 1'b0);
    tick_n(16 * 16);
    check("brk_err",  err_cnt - e0, 1);
    check("brk_rdy",  rdy_cnt - r0, 0);
    check("brk_data", rx_if.rxData, 8'h0A);
    check("brk_busy", rx_if.rxBusy, 0);
    r0 = rdy_cnt;
    send_frame(8'h33, 1'b1);
    tick_n(20);
    check("f33_rdy",  rdy_cnt - r0, 1);
    check("f33_data", rx_if.rxData, 8'h33);

    r0 = rdy_cnt; e0 = err_cnt;
    v = 8'hA5;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(v[i]);
    rxd = v[4];
    tick_n(8);
    check("mid_busy", rx_if.rxBusy, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    tick_n(2);
    check("mr_data", rx_if.rxData,  0);
    check("mr_busy", rx_if.rxBusy,  0);
    check("mr_rdy",  rx_if.rxReady, 0);
    check("mr_err",  rx_if.rxError, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    rxd = 1'b1;
    tick_n(48);
    check("mr_rdy_cnt", rdy_cnt - r0, 0);
    check("mr_err_cnt", err_cnt - e0, 0);
    r0 = rdy_cnt;
    send_frame(8'h3C, 1'b1);
    tick_n(20);
    check("f3c_rdy",  rdy_cnt - r0, 1);
    check("f3c_data", rx_if.rxData, 8'h3C);

    r0 = rdy_cnt; e0 = err_cnt;
    qs = got_q.size();
    send_frame(8'hFF, 1'b1);
    send_frame(8'h00, 1'b1);
    tick_n(20);
    check("bb_rdy", rdy_cnt - r0, 2);
    check("bb_err", err_cnt - e0, 0);
    if (got_q.size() >= qs + 2) begin
      check("bb_first",  got_q[qs],     8'hFF);
      check("bb_second", got_q[qs + 1], 8'h00);
    end else begin
      check("bb_qsize", got_q.size(), qs + 2);
    end

`ifdef UART_RX_PARITY_EN
    r0 = rdy_cnt; e0 = err_cnt;
    send_frame_p(8'h01, 1'b1);
    tick_n(20);
    check("par_ok_rdy",  rdy_cnt - r0, 1);
    check("par_ok_data", rx_if.rxData, 8'h01);
    check("par_ok_err",  err_cnt - e0, 0);
    r0 = rdy_cnt; e0 = err_cnt;
    send_frame_p(8'h01, 1'b0);
    tick_n(20);
    check("par_bad_rdy",  rdy_cnt - r0, 0);
    check("par_bad_err",  err_cnt - e0, 1);
    check("par_bad_data", rx_if.rxData, 8'h01);
`endif

    check("rdy_err_overlap", both_cnt, 0);
    check("data_stray_chg",  dchg_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate.
REQ-003 Port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port rxd  input  1  asynchronous serial line; idle high; 8N1 frame, LSB first.
REQ-006 Port rxReady  output  1  one-clk pulse; rxData holds a new valid byte.
REQ-007 Port rxData  output  8  last correctly received byte.
REQ-008 Port rxError  output  1  one-clk pulse on a framing error (or parity error when enabled).
REQ-009 Port rxBusy  output  1  high from start-bit detect until frame end.

Function
REQ-010 rxd SHALL pass through a 2-flop synchronizer; both flops reset to 1; all decoding SHALL use the synchronized value.
REQ-011 Oversample tick SHALL pulse once every DIV = CLK_FREQ/(BAUD*16) clocks (integer truncation; DIV < 1 rejected at elaboration).
REQ-012 Tick counter SHALL restart at 0 on the clock a start edge is detected, so frame sampling is phase-aligned to the edge.
REQ-013 States SHALL be IDLE, START, DATA, [PARITY], STOP, BREAK.
REQ-014 IDLE: a 1->0 transition of the synchronized line SHALL enter START and assert rxBusy.
REQ-015 START: at tick 8, line still 0 -> DATA with bit index 0; line 1 -> IDLE (glitch rejected, no output pulse).
REQ-016 Each bit SHALL last 16 ticks; its value SHALL be the majority of samples at ticks 7, 8, 9 of that bit.
REQ-017 DATA SHALL shift bits in LSB first; after bit index 7 the next state is PARITY (if enabled) else STOP; the 3-bit index wraps 7->0.
REQ-018 STOP: after its mid-bit sample (tick 9), value 1 SHALL update rxData and pulse rxReady on the next clock, then go to IDLE.
REQ-019 STOP value 0 SHALL pulse rxError, leave rxData unchanged, and enter BREAK.
REQ-020 BREAK SHALL stay until the synchronized line has been 1 for 16 consecutive ticks, then go to IDLE; no start detection in BREAK.
REQ-021 rxReady and rxError SHALL never be high in the same clock; each is high for exactly one clock per frame.
REQ-022 rxData SHALL change only in the clock rxReady rises.
REQ-023 rxBusy SHALL drop in the clock the state returns to IDLE.
REQ-024 A start bit beginning half a bit after the stop sample SHALL be received without loss (back-to-back frames).

Reset
REQ-025 rst_n low SHALL immediately force: state IDLE, rxData 0x00, rxReady 0, rxError 0, rxBusy 0, counters 0, synchronizer 1.
REQ-026 Reset asserted mid-frame SHALL discard the partial byte; after release the next falling edge starts a fresh frame.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: one even-parity bit between bit 7 and stop; a mismatch pulses rxError in place of rxReady after the stop sample and rxData is unchanged; STOP handling is otherwise identical.
REQ-028 Macro undefined: PARITY state and its logic absent; 8N1 only.

Structure
REQ-029 Shared package uart_pkg SHALL hold the state enum, OVERSAMPLE=16, MID_TICK=8 and the majority sample indices.
REQ-030 Sub-module uart_baud_tick SHALL generate the oversample tick and accept a synchronous restart input.

Verification (CLK_FREQ=16000000, BAUD=1000000: DIV=1, one bit = 16 clks)
REQ-031 Frame 0x0A (1 start, 8 data, 1 stop) -> one rxReady pulse, rxData=0x0A, rxError never high.
REQ-032 Low glitch of 4 clks on idle line -> no rxReady, no rxError, rxBusy back to 0 within 10 clks.
REQ-033 Frame 0x55 with stop bit forced 0 -> rxError one pulse, rxData keeps its previous value 0x0A; line then high for 16 bits -> next frame 0x33 received correctly.
REQ-034 Frames 0xFF then 0x00 back-to-back, no idle gap -> two rxReady pulses, values in order.
REQ-035 rst_n pulsed low during data bit 4 of 0xA5 -> no rxReady for that frame, outputs at reset values; a following 0x3C is received correctly.
REQ-036 With UART_RX_PARITY_EN: 0x01 with parity bit 1 -> rxReady, rxData=0x01; parity bit 0 -> rxError only.
